// File: rtl/vector_store_sequencer_pkg.sv
// Shared vector-datapath constants and the store sequencer state encoding.
package vec_pkg;
  localparam int LANES       = 4;
  localparam int LANE_W      = 32;
  localparam int VREG_W      = 128;
  localparam int VREG_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } vst_state_t;
endpackage

// File: rtl/vector_store_sequencer_if.sv
// Word-wide data memory write port with a ready handshake.
interface vector_store_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int LANE_W = vec_pkg::LANE_W
) ();
  logic              mem_write_enable;
  logic [ADDR_W-1:0] mem_addr;
  logic [LANE_W-1:0] mem_write_data;
  logic              mem_ready;

  modport master (output mem_write_enable, mem_addr, mem_write_data, input mem_ready);
  modport slave  (input mem_write_enable, mem_addr, mem_write_data, output mem_ready);
endinterface

// File: rtl/vector_store_sequencer_lane_priority.sv
// Combinational lowest-set-bit finder over a lane mask.
module vec_lane_priority #(
  parameter int LANES = vec_pkg::LANES,
  parameter int IDX_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic [LANES-1:0] mask,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);
  // Scan from the top so the lowest set bit is the last one to win.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/vector_store_sequencer.sv
// Streams one vector register to memory as masked, ready-handshaked lane writes.
module vector_store_sequencer #(
  parameter int LANES  = vec_pkg::LANES,
  parameter int LANE_W = vec_pkg::LANE_W,
  parameter int ADDR_W = 32
) (
  input  logic                                clock,
  input  logic                                async_reset,
  input  logic                                start,
  input  logic [vec_pkg::VREG_ADDR_W-1:0]     src_reg,
  input  logic [ADDR_W-1:0]                   base_addr,
  input  logic [LANES-1:0]                    lane_mask,
  output logic [vec_pkg::VREG_ADDR_W-1:0]     rf_read_addr,
  input  logic [LANES*LANE_W-1:0]             rf_read_data,
  vector_store_sequencer_if.master            mem,
  output logic                                busy,
  output logic                                done
);
  import vec_pkg::*;

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  vst_state_t               state, next_state;
  logic [VREG_ADDR_W-1:0]   src_q;
  logic [ADDR_W-1:0]        base_q;
  logic [LANES-1:0]         mask_q, scan_mask;
  logic [LANES*LANE_W-1:0]  buffer;
  logic [IDX_W-1:0]         idx_q, scan_idx;
  logic                     scan_valid;
  logic                     in_write;

  // In WRITE the finder looks past the lane currently on the bus, so the
  // next index is ready the moment the current write is accepted.
  vec_lane_priority #(.LANES(LANES), .IDX_W(IDX_W)) u_prio (
    .mask  (scan_mask),
    .idx   (scan_idx),
    .valid (scan_valid)
  );

  always_comb begin
    next_state = state;
    scan_mask  = mask_q;
    case (state)
      IDLE:  if (start) next_state = READ;
      READ:  next_state = scan_valid ? WRITE : DONE;
      WRITE: begin
        scan_mask = mask_q & ~(LANES'(1) << idx_q);
        if (mem.mem_ready) next_state = scan_valid ? WRITE : DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge async_reset) begin
    if (!async_reset) begin
      state  <= IDLE;
      src_q  <= '0;
      base_q <= '0;
      mask_q <= '0;
      buffer <= '0;
      idx_q  <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: if (start) begin
          src_q  <= src_reg;
          base_q <= base_addr;
          mask_q <= lane_mask;
        end
        READ: begin
          buffer <= rf_read_data;
          idx_q  <= scan_idx;
        end
        WRITE: if (mem.mem_ready) begin
          mask_q <= scan_mask;
          idx_q  <= scan_idx;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from registered state only, so a reset clears them at once.
  assign in_write             = (state == WRITE);
  assign busy                 = (state != IDLE);
  assign done                 = (state == DONE);
  assign rf_read_addr         = src_q;
  assign mem.mem_write_enable = in_write;
  assign mem.mem_addr         = in_write ? base_q + (ADDR_W'(idx_q) << 2) : '0;
  assign mem.mem_write_data   = in_write ? buffer[idx_q*LANE_W +: LANE_W] : '0;
endmodule

// File: tb/tb_vector_store_sequencer.sv
// Bench for vector_store_sequencer: register-file model plus a queue-based store model.
module tb_vector_store_sequencer;
  logic         clock;
  logic         async_reset;
  logic         start;
  logic [4:0]   src_reg;
  logic [31:0]  base_addr;
  logic [3:0]   lane_mask;
  logic [4:0]   rf_read_addr;
  logic [127:0] rf_read_data;
  logic         busy;
  logic         done;

  logic [127:0] rf [32];
  int n_cmp = 0;
  int n_err = 0;

  vector_store_sequencer_if #(.ADDR_W(32), .LANE_W(32)) mem_bus ();

  vector_store_sequencer #(.LANES(4), .LANE_W(32), .ADDR_W(32)) dut (
    .clock        (clock),
    .async_reset  (async_reset),
    .start        (start),
    .src_reg      (src_reg),
    .base_addr    (base_addr),
    .lane_mask    (lane_mask),
    .rf_read_addr (rf_read_addr),
    .rf_read_data (rf_read_data),
    .mem          (mem_bus),
    .busy         (busy),
    .done         (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register 0 is hardwired to zero.
  assign rf_read_data = (rf_read_addr == 5'd0) ? 128'h0 : rf[rf_read_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane_of(input logic [4:0] s, input int i);
    logic [127:0] v;
    v = (s == 5'd0) ? 128'h0 : rf[s];
    return v[i*32 +: 32];
  endfunction

  // One store: expected writes are the set mask lanes in ascending order;
  // each is held until a ready cycle, then one done cycle, then idle.
  task automatic run_store(input logic [4:0] src, input logic [31:0] base,
                           input logic [3:0] mask, input int stall_lane,
                           input int stall_n, input bit rand_ready,
                           input bit poke_start, input bit rf_update);
    logic [31:0] ea[$];
    logic [31:0] ed[$];
    int          el[$];
    int          k, stalls, stall_left, c, pop;
    bit          done_seen, fin;
    @(negedge clock);
    start = 1'b1; src_reg = src; base_addr = base; lane_mask = mask;
    @(posedge clock); #1;
    start = 1'b0;
    src_reg = 5'($urandom); base_addr = $urandom; lane_mask = 4'($urandom);
    mem_bus.mem_ready = 1'($urandom);
    #1;
    chk("read_busy", 32'(busy), 32'd1);
    chk("read_we", 32'(mem_bus.mem_write_enable), 32'd0);
    chk("read_done", 32'(done), 32'd0);
    chk("read_rf_addr", 32'(rf_read_addr), 32'(src));
    @(negedge clock);
    if (rf_update && src != 5'd0) rf[src] = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        ea.push_back(base + 32'(4 * i));
        ed.push_back(lane_of(src, i));
        el.push_back(i);
      end
    end
    pop = ea.size(); k = 0; stalls = 0; stall_left = stall_n;
    done_seen = 1'b0; fin = 1'b0;
    for (c = 2; c < 40 && !fin; c++) begin
      @(posedge clock); #1;
      if (poke_start && c == 3) begin
        start = 1'b1; lane_mask = 4'hF; base_addr = $urandom;
      end else start = 1'b0;
      if (k < pop) begin
        if (el[k] == stall_lane && stall_left > 0) begin
          mem_bus.mem_ready = 1'b0; stall_left--;
        end else if (rand_ready) mem_bus.mem_ready = 1'($urandom_range(0, 1));
        else mem_bus.mem_ready = 1'b1;
        if (!mem_bus.mem_ready) stalls++;
      end else mem_bus.mem_ready = 1'($urandom);
      #1;
      chk("rf_addr", 32'(rf_read_addr), 32'(src));
      if (k < pop) begin
        chk("wr_we", 32'(mem_bus.mem_write_enable), 32'd1);
        chk("wr_addr", mem_bus.mem_addr, ea[k]);
        chk("wr_data", mem_bus.mem_write_data, ed[k]);
        chk("wr_busy", 32'(busy), 32'd1);
        chk("wr_done", 32'(done), 32'd0);
        if (mem_bus.mem_ready) k++;
      end else if (!done_seen) begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_we", 32'(mem_bus.mem_write_enable), 32'd0);
        chk("done_cycle", 32'(c), 32'(2 + pop + stalls));
        done_seen = 1'b1;
      end else begin
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_we", 32'(mem_bus.mem_write_enable), 32'd0);
        chk("idle_addr", mem_bus.mem_addr, 32'd0);
        chk("idle_data", mem_bus.mem_write_data, 32'd0);
        fin = 1'b1;
      end
    end
    start = 1'b0;
    chk("store_terminated", 32'(fin), 32'd1);
  endtask

  task automatic run_reset_abort();
    @(negedge clock);
    start = 1'b1; src_reg = 5'd5; base_addr = 32'h3000; lane_mask = 4'hF;
    mem_bus.mem_ready = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("abort_pre_we", 32'(mem_bus.mem_write_enable), 32'd1);
    chk("abort_pre_addr", mem_bus.mem_addr, 32'h3004);
    #2 async_reset = 1'b0;
    #1;
    chk("abort_we", 32'(mem_bus.mem_write_enable), 32'd0);
    chk("abort_addr", mem_bus.mem_addr, 32'd0);
    chk("abort_data", mem_bus.mem_write_data, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_rf_addr", 32'(rf_read_addr), 32'd0);
    repeat (3) begin
      @(posedge clock); #1;
      chk("abort_hold_done", 32'(done), 32'd0);
      chk("abort_hold_we", 32'(mem_bus.mem_write_enable), 32'd0);
      chk("abort_hold_busy", 32'(busy), 32'd0);
    end
    @(negedge clock);
    async_reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    async_reset = 1'b0; start = 1'b0; src_reg = '0; base_addr = '0; lane_mask = '0;
    mem_bus.mem_ready = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = {$urandom, $urandom, $urandom, $urandom};
    rf[5] = 128'h44444444_33333333_22222222_11111111;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(mem_bus.mem_write_enable), 32'd0);
    chk("rst_addr", mem_bus.mem_addr, 32'd0);
    chk("rst_data", mem_bus.mem_write_data, 32'd0);
    chk("rst_rf_addr", 32'(rf_read_addr), 32'd0);
    @(negedge clock);
    async_reset = 1'b1;

    run_store(5'd5, 32'h1000, 4'hF, -1, 0, 1'b0, 1'b0, 1'b0);
    run_store(5'd5, 32'h2000, 4'b1010, -1, 0, 1'b0, 1'b0, 1'b0);
    run_store(5'd7, 32'h4000, 4'h0, -1, 0, 1'b0, 1'b0, 1'b0);
    run_store(5'd5, 32'h1000, 4'hF, 2, 3, 1'b0, 1'b1, 1'b0);
    run_store(5'd0, 32'hFFFF_FFF8, 4'hF, -1, 0, 1'b0, 1'b0, 1'b0);
    run_reset_abort();
    run_store(5'd5, 32'h5000, 4'hF, -1, 0, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 12; r++)
      run_store(5'($urandom), $urandom, 4'($urandom), -1, 0, 1'b1, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
